// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
// Shares the single register-file write port between the writeback stage
// and a multi-cycle (MC) execution unit. Writeback normally wins; a
// starvation counter forces one MC grant by stalling writeback for a cycle.
// The grant path is purely combinational; only the FSM state, the wait
// counter and the optional statistics counter are registered.
//
// Optional feature macro: WB_ARB_STATS_EN
//   defined   -> STALL_CNT counts WB_STALL cycles (saturating, cleared by RST)
//   undefined -> STALL_CNT is tied to zero and no counter is built

module rf_write_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        WB_REG_WRITE,
    input  logic [4:0]  WB_WA,
    input  logic [31:0] WB_WD,
    input  logic        MC_VALID,
    input  logic [4:0]  MC_WA,
    input  logic [31:0] MC_WD,
    output logic        MC_READY,
    output logic        WB_STALL,
    output logic        RF_WE,
    output logic [4:0]  RF_WA,
    output logic [31:0] RF_WD,
    output logic [15:0] STALL_CNT
);

    // Wide enough to hold STARVE_LIMIT itself.
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FORCE = 1'b1
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_wait_cnt;
    logic [CW-1:0]   w_wait_inc;

    logic            w_wb_req;
    logic            w_mc_nonzero;
    logic            w_force_active;
    logic            w_mc_denied;

    logic            w_we;
    logic [4:0]      w_wa;
    logic [31:0]     w_wd;
    logic            w_ready;
    logic            w_stall;

    // A writeback to x0 is indistinguishable from no writeback at all.
    assign w_wb_req       = WB_REG_WRITE && (WB_WA != 5'd0);
    assign w_mc_nonzero   = (MC_WA != 5'd0);
    // A forced grant only happens when MC is actually presenting a result;
    // otherwise the FORCE cycle behaves exactly like IDLE.
    assign w_force_active = (r_state == ST_FORCE) && MC_VALID;
    assign w_mc_denied    = MC_VALID && !w_ready;
    assign w_wait_inc     = r_wait_cnt + 1'b1;

    // Combinational grant: decide who owns the write port this cycle.
    always_comb begin
        w_we    = 1'b0;
        w_wa    = 5'd0;
        w_wd    = 32'd0;
        w_ready = 1'b0;
        w_stall = 1'b0;
        if (!RST) begin
            if (w_force_active) begin
                // Starved MC result takes the port; writeback holds.
                w_stall = 1'b1;
                w_ready = 1'b1;
                if (w_mc_nonzero) begin
                    w_we = 1'b1;
                    w_wa = MC_WA;
                    w_wd = MC_WD;
                end
            end else if (w_wb_req) begin
                // Writeback wins; an MC result to x0 needs no port and is
                // retired alongside it.
                w_we    = 1'b1;
                w_wa    = WB_WA;
                w_wd    = WB_WD;
                w_ready = MC_VALID && !w_mc_nonzero;
            end else if (MC_VALID) begin
                w_ready = 1'b1;
                if (w_mc_nonzero) begin
                    w_we = 1'b1;
                    w_wa = MC_WA;
                    w_wd = MC_WD;
                end
            end
        end
    end

    assign RF_WE    = w_we;
    assign RF_WA    = w_wa;
    assign RF_WD    = w_wd;
    assign MC_READY = w_ready;
    assign WB_STALL = w_stall;

    // Starvation FSM: count consecutive denied MC cycles, force one grant.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_mc_denied) begin
                        r_wait_cnt <= w_wait_inc;
                        if (w_wait_inc == LIMIT) begin
                            r_state <= ST_FORCE;
                        end
                    end else begin
                        r_wait_cnt <= '0;
                    end
                end
                ST_FORCE: begin
                    // Always exactly one cycle, so WB_STALL can never be
                    // asserted on two consecutive cycles.
                    r_state    <= ST_IDLE;
                    r_wait_cnt <= '0;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

`ifdef WB_ARB_STATS_EN
    logic [15:0] r_stall_cnt;

    // Saturating count of writeback stall cycles.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stall_cnt <= 16'd0;
        end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign STALL_CNT = r_stall_cnt;
`else
    assign STALL_CNT = 16'd0;
`endif

endmodule
